// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3).
//
// A conversion takes one bit per cycle. It starts when start is seen high
// in IDLE, and its result is published one cycle after the last shift.
//
// Ports:
//   CLOCK_50  in   single clock, rising edge
//   RESET_N   in   asynchronous active-low reset
//   start     in   conversion request, sampled only in IDLE
//   bin       in   WIDTH-bit unsigned operand, captured on an accepted start
//   busy      out  high while shifting
//   done      out  one-cycle pulse when bcd/overflow are updated
//   bcd       out  4*DIGITS-bit packed BCD result, digit 0 in [3:0]
//   overflow  out  result did not fit in DIGITS digits (bcd is value mod 10^DIGITS)
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one add-3 / shift step per cycle, WIDTH cycles in total
// DONE  | publish scratch to bcd/overflow, pulse done
module bin2bcd_seq #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  sreg;
  logic [BW-1:0]     scratch;
  logic              ovf_s;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     adj;

  // Digits >= 5 get +3 before the shift so that doubling carries into the
  // next digit exactly like decimal.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      sreg     <= '0;
      scratch  <= '0;
      ovf_s    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sreg    <= bin;
            scratch <= '0;
            ovf_s   <= 1'b0;
            cnt     <= CW'(WIDTH);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {adj[BW-2:0], sreg[WIDTH-1]};
          sreg    <= {sreg[WIDTH-2:0], 1'b0};
          // A bit leaving the top digit means the value exceeds DIGITS digits.
          if (adj[BW-1]) begin
            ovf_s <= 1'b1;
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          bcd      <= scratch;
          overflow <= ovf_s;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: three instances (10/4, 10/3, 16/5) with
// per-instance expected-result queues checked by done-triggered monitors.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance a: WIDTH=10, DIGITS=4
  logic        rst_a, start_a, busy_a, done_a, ovf_a;
  logic [9:0]  bin_a;
  logic [15:0] bcd_a;
  // instance b: WIDTH=10, DIGITS=3
  logic        rst_n, start_b, busy_b, done_b, ovf_b;
  logic [9:0]  bin_b;
  logic [11:0] bcd_b;
  // instance c: WIDTH=16, DIGITS=5
  logic        start_c, busy_c, done_c, ovf_c;
  logic [15:0] bin_c;
  logic [19:0] bcd_c;

  bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) dut_a (
    .CLOCK_50(clk), .RESET_N(rst_a), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a));

  bin2bcd_seq #(.WIDTH(10), .DIGITS(3)) dut_b (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b));

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut_c (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start_c), .bin(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c));

  logic [16:0] qa[$];
  logic [12:0] qb[$];
  logic [20:0] qc[$];
  logic [16:0] prev_a = '0;
  int          last_c = -1;
  int          dones_c = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitors: compare each published result with the oldest expectation
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      if (qa.size() == 0) check("a_unexpected_done", 32'd1, 32'd0);
      else check("a_result", {15'd0, ovf_a, bcd_a}, {15'd0, qa.pop_front()});
    end
    if (done_b === 1'b1) begin
      if (qb.size() == 0) check("b_unexpected_done", 32'd1, 32'd0);
      else check("b_result", {19'd0, ovf_b, bcd_b}, {19'd0, qb.pop_front()});
    end
    if (done_c === 1'b1) begin
      if (qc.size() == 0) check("c_unexpected_done", 32'd1, 32'd0);
      else check("c_result", {11'd0, ovf_c, bcd_c}, {11'd0, qc.pop_front()});
      if (last_c >= 0) check("c_period", cyc - last_c, 32'd18);
      last_c = cyc;
      dones_c++;
    end
  end

  // one conversion on instance a with full cycle-by-cycle timing checks
  task automatic run_a(input logic [9:0] v, input logic [15:0] exp_bcd, input logic exp_ovf);
    @(negedge clk);
    bin_a = v; start_a = 1'b1;
    qa.push_back({exp_ovf, exp_bcd});
    @(negedge clk);
    start_a = 1'b0;
    bin_a   = ~v;  // must not disturb the captured operand
    for (int i = 0; i < 10; i++) begin
      check("a_busy_shift", {30'd0, busy_a, done_a}, 32'd2);
      check("a_hold_shift", {15'd0, ovf_a, bcd_a}, {15'd0, prev_a});
      @(negedge clk);
    end
    check("a_in_done_state", {30'd0, busy_a, done_a}, 32'd0);
    @(negedge clk);
    check("a_done_pulse", {31'd0, done_a}, 32'd1);
    prev_a = {exp_ovf, exp_bcd};
    @(negedge clk);
    check("a_done_one_cycle", {31'd0, done_a}, 32'd0);
  endtask

  task automatic run_b(input logic [9:0] v, input logic [11:0] exp_bcd, input logic exp_ovf);
    @(negedge clk);
    bin_b = v; start_b = 1'b1;
    qb.push_back({exp_ovf, exp_bcd});
    @(negedge clk);
    start_b = 1'b0;
    repeat (13) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bin_a = '0; bin_b = '0; bin_c = '0;
    repeat (3) @(negedge clk);
    check("reset_a_outputs", {14'd0, busy_a, done_a, ovf_a, bcd_a}, 32'd0);
    check("reset_c_outputs", {9'd0, busy_c, done_c, ovf_c, bcd_c}, 32'd0);
    rst_a = 1'b1; rst_n = 1'b1;

    // directed conversions, WIDTH=10 DIGITS=4
    run_a(10'd1023, 16'h1023, 1'b0);
    run_a(10'd0,    16'h0000, 1'b0);
    run_a(10'd999,  16'h0999, 1'b0);
    run_a(10'd500,  16'h0500, 1'b0);

    // start during SHIFT is ignored
    @(negedge clk);
    bin_a = 10'd37; start_a = 1'b1;
    qa.push_back({1'b0, 16'h0037});
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    bin_a = 10'd512; start_a = 1'b1;  // SHIFT cycle 4
    @(negedge clk);
    start_a = 1'b0;
    repeat (25) @(negedge clk);
    check("ignored_start_queue_empty", qa.size(), 32'd0);
    check("ignored_start_idle", {31'd0, busy_a}, 32'd0);
    check("ignored_start_result", {16'd0, bcd_a}, 32'h0037);

    // reset in the middle of a conversion
    @(negedge clk);
    bin_a = 10'd1023; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    rst_a = 1'b0;
    #1;
    check("abort_outputs_zero", {14'd0, busy_a, done_a, ovf_a, bcd_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    prev_a = '0;
    repeat (12) @(negedge clk);
    check("abort_no_done", qa.size(), 32'd0);
    run_a(10'd7, 16'h0007, 1'b0);

    // overflow, WIDTH=10 DIGITS=3
    run_b(10'd1000, 12'h000, 1'b1);
    run_b(10'd1023, 12'h023, 1'b1);
    run_b(10'd42,   12'h042, 1'b0);
    check("b_queue_empty", qb.size(), 32'd0);

    // start held high, WIDTH=16 DIGITS=5: three conversions 18 cycles apart
    @(negedge clk);
    bin_c = 16'd65535; start_c = 1'b1;
    repeat (3) qc.push_back({1'b0, 20'h65535});
    repeat (37) @(negedge clk);
    start_c = 1'b0;
    repeat (20) @(negedge clk);
    check("c_done_count", dones_c, 32'd3);
    check("c_queue_empty", qc.size(), 32'd0);
    check("a_queue_empty", qa.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, giving the binary input width; legal range 4..32.
REQ-002 The block SHALL have parameter DIGITS, default 4, giving the number of BCD output digits; legal range 1..10.
REQ-003 The block SHALL have port CLOCK_50, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET_N, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-006 The block SHALL have port bin, input, WIDTH bits: unsigned binary operand, captured on an accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when a result is published.
REQ-009 The block SHALL have port bcd, output, 4*DIGITS bits: packed BCD result, digit 0 in bits [3:0].
REQ-010 The block SHALL have port overflow, output, 1 bit: high when the last result did not fit in DIGITS digits.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1, the block SHALL capture bin into a shift register, clear the BCD scratch and the overflow scratch, load the bit counter with WIDTH, and enter SHIFT on the next edge.
REQ-013 In IDLE with start=0, the block SHALL remain in IDLE with all registers unchanged.
REQ-014 On each SHIFT cycle, the block SHALL first add 3 to every scratch digit that is >= 5, then shift {scratch, shift register} left by one bit, inserting the shift-register MSB into digit 0 LSB.
REQ-015 On each SHIFT cycle, a 1 shifted out of the top scratch digit SHALL set the overflow scratch, which is sticky until the next accepted start.
REQ-016 The bit counter SHALL decrement once per SHIFT cycle, and the FSM SHALL enter DONE after exactly WIDTH SHIFT cycles.
REQ-017 In DONE, the block SHALL load bcd and overflow from scratch, assert done for exactly one cycle, and return to IDLE on the next edge.
REQ-018 For an accepted start sampled at edge T, busy SHALL be high in cycles T+1..T+WIDTH, and done plus the updated bcd/overflow SHALL be visible after edge T+WIDTH+1.
REQ-019 The bcd and overflow outputs SHALL hold the last published result until the next DONE; they SHALL NOT change during SHIFT.
REQ-020 The block SHALL ignore start while in SHIFT or DONE; a request is not queued, and start must be high in IDLE to be accepted.
REQ-021 Changes on bin after capture SHALL have no effect on the conversion in progress.
REQ-022 With start held high continuously, back-to-back conversions SHALL occur with a period of WIDTH+2 cycles.
REQ-023 When overflow=1, bcd SHALL equal the value modulo 10^DIGITS.
REQ-024 The scratch width SHALL be 4*DIGITS bits, the bit counter SHALL be ceil(log2(WIDTH+1)) bits, and the block SHALL contain no combinational path from inputs to outputs.

Reset
REQ-025 While RESET_N=0, the block SHALL hold the FSM in IDLE, and bcd, overflow, done, busy, scratch, shift register and counter SHALL all be 0, asynchronously.
REQ-026 Reset asserted mid-SHIFT SHALL abort the conversion, and no done pulse SHALL follow.
REQ-027 After RESET_N rises, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-028 Scenario, WIDTH=10, DIGITS=4: bin=1023, one-cycle start -> busy high for 10 cycles; done pulse 11 cycles after start edge; bcd=16'h1023; overflow=0.
REQ-029 Scenario, WIDTH=10, DIGITS=4: bin=0 -> bcd=16'h0000, overflow=0; separately bin=999 -> bcd=16'h0999, and bin=500 -> bcd=16'h0500.
REQ-030 Scenario, start ignored: start bin=37, then pulse start with bin=512 at cycle 4 of SHIFT -> exactly one done; bcd=16'h0037; no second conversion.
REQ-031 Scenario, WIDTH=10, DIGITS=3: bin=1000 -> overflow=1, bcd=12'h000; bin=1023 -> overflow=1, bcd=12'h023; a following bin=42 -> overflow=0, bcd=12'h042.
REQ-032 Scenario, reset mid-operation: start bin=1023, assert RESET_N=0 at SHIFT cycle 5 -> outputs 0 immediately; no done; a new start bin=7 after release -> bcd=16'h0007.
REQ-033 Scenario, WIDTH=16, DIGITS=5: start held high continuously, bin=65535 -> done every 18 cycles; bcd=20'h65535.
